// File: rtl/fetch_seq_pkg.sv
// Shared types and mux-select encodings for the fetch-stage sequencer.
// The select encodings match the fetch datapath's mux input ordering.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] PCSEL_Z4   = 2'd0;
    localparam logic [1:0] PCSEL_INC  = 2'd1;
    localparam logic [1:0] PCSEL_HOLD = 2'd2;
    localparam logic [1:0] PCSEL_BR   = 2'd3;

    localparam logic [1:0] IRSEL_MEM  = 2'd0;
    localparam logic [1:0] IRSEL_NOP  = 2'd1;
    localparam logic [1:0] IRSEL_HOLD = 2'd2;

    localparam logic PC2SEL_INC  = 1'b0;
    localparam logic PC2SEL_HOLD = 1'b1;

endpackage

// File: rtl/fetch_sequencer_bubble_counter.sv
// 4-bit loadable down-counter that times the nop bubbles after a redirect.
// last is high while the count sits at 1, i.e. in the final bubble cycle.
module bubble_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       last
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign last = (count == 4'd1);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: drives the PC, IR2 and PC2 mux selects every cycle
// and counts retired fetches for performance debug.
//
// state | meaning
// BOOT  | load PC from z4, IR2 gets a nop
// RUN   | normal PC+4 fetch
// STALL | decode hazard, PC/PC2/IR2 held
// FLUSH | nop bubbles after a taken-branch redirect
// HALT  | fetch stopped until restart
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             restart,
    input  logic             halt,
    output logic [1:0]       selectmux0,
    output logic [1:0]       selectmux1,
    output logic             selectmux2,
    output logic             fetch_valid,
    output logic [CNT_W-1:0] fetch_count
);

    state_t     state;
    state_t     state_next;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic       sel2;
    logic       bc_load;
    logic       bc_dec;
    logic       bc_last;

    bubble_counter u_bubble_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (bc_load),
        .load_value (4'(FLUSH_CYCLES)),
        .dec        (bc_dec),
        .last       (bc_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Mealy decode: selects must act on the same edge that samples the event.
    always_comb begin
        state_next = state;
        sel0       = PCSEL_HOLD;
        sel1       = IRSEL_NOP;
        sel2       = PC2SEL_HOLD;
        bc_load    = 1'b0;
        bc_dec     = 1'b0;

        case (state)
            ST_BOOT: begin
                sel0       = PCSEL_Z4;
                sel2       = PC2SEL_INC;
                state_next = ST_RUN;
            end

            ST_RUN, ST_STALL: begin
                if (restart) begin
                    sel0       = PCSEL_Z4;
                    sel2       = PC2SEL_INC;
                    state_next = ST_BOOT;
                end else if (branch_taken) begin
                    sel0       = PCSEL_BR;
                    bc_load    = 1'b1;
                    state_next = ST_FLUSH;
                end else if (halt) begin
                    state_next = ST_HALT;
                end else if (stall) begin
                    sel1       = IRSEL_HOLD;
                    state_next = ST_STALL;
                end else begin
                    sel0       = PCSEL_INC;
                    sel1       = IRSEL_MEM;
                    sel2       = PC2SEL_INC;
                    state_next = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (restart) begin
                    sel0       = PCSEL_Z4;
                    sel2       = PC2SEL_INC;
                    state_next = ST_BOOT;
                end else if (branch_taken) begin
                    sel0    = PCSEL_BR;
                    bc_load = 1'b1;
                end else if (halt) begin
                    state_next = ST_HALT;
                end else begin
                    bc_dec = 1'b1;
                    if (bc_last) begin
                        state_next = ST_RUN;
                    end
                end
            end

            ST_HALT: begin
                if (restart) begin
                    sel0       = PCSEL_Z4;
                    sel2       = PC2SEL_INC;
                    state_next = ST_BOOT;
                end
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase

        if (!rst_n) begin
            sel0 = PCSEL_Z4;
            sel1 = IRSEL_NOP;
            sel2 = PC2SEL_INC;
        end
    end

    assign selectmux0  = sel0;
    assign selectmux1  = sel1;
    assign selectmux2  = sel2;
    assign fetch_valid = (sel1 == IRSEL_MEM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (fetch_valid) begin
            fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
